// File: rtl/bec_core_sequencer.sv
// Sequencer for a 163-bit binary-field point-arithmetic core: chunked operand load,
// start/done/timeout supervision and chunked result readback over ready/valid.
module bec_core_sequencer #(
    parameter int WIDTH   = 163,
    parameter int CHUNK   = 82,
    parameter int NREGS   = 7,
    parameter int NRES    = 2,
    parameter int TIMEOUT = 2000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [3:0]             wr_addr,
    input  logic                   wr_hi,
    input  logic [CHUNK-1:0]       wr_data,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   err_clr,
    output logic                   core_start,
    input  logic                   core_done,
    output logic [NREGS*WIDTH-1:0] op_bus,
    input  logic [NRES*WIDTH-1:0]  res_bus,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [CHUNK-1:0]       rd_data,
    output logic                   rd_last,
    output logic                   busy,
    output logic [2:0]             state_o,
    output logic                   err_timeout,
    output logic                   err_addr,
    output logic                   err_incomplete
);
    localparam int NCHUNK = 2;
    localparam int NMASK  = NREGS * NCHUNK;
    localparam int NRD    = NRES * NCHUNK;
    localparam int TW     = $clog2(TIMEOUT + 1);
    localparam int IW     = $clog2(NRD + 1);
    localparam int HW     = WIDTH - CHUNK;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_SAT  = TW'(TIMEOUT);
    localparam logic [IW-1:0] I_LAST = IW'(NRD - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t                   state_r, state_n;
    logic [NREGS*WIDTH-1:0]   op_r, op_n;
    logic [NRES*WIDTH-1:0]    res_r, res_n;
    logic [NMASK-1:0]         mask_r, mask_n;
    logic [TW-1:0]            timer_r, timer_n;
    logic [IW-1:0]            idx_r, idx_n;
    logic [CHUNK-1:0]         rd_data_r, rd_data_n;
    logic                     rd_last_r, rd_last_n;
    logic                     core_start_r, core_start_n;
    logic                     err_to_r, err_to_n;
    logic                     err_addr_r, err_addr_n;
    logic                     err_inc_r, err_inc_n;
    logic                     wr_ready_s, rd_valid_s, wr_acc_s, rd_hs_s;

    // Result chunk idx: even = low CHUNK bits, odd = upper bits zero-extended.
    function automatic logic [CHUNK-1:0] chunk_sel(input logic [NRES*WIDTH-1:0] res,
                                                   input logic [IW-1:0] idx);
        logic [WIDTH-1:0] w;
        logic [CHUNK-1:0] c;
        int               r;
        r = int'(idx) / NCHUNK;
        w = res[r*WIDTH +: WIDTH];
        c = '0;
        if (idx[0]) begin
            c[HW-1:0] = w[WIDTH-1:CHUNK];
        end else begin
            c = w[CHUNK-1:0];
        end
        return c;
    endfunction

    assign wr_ready_s = (state_r == ST_IDLE) || (state_r == ST_LOAD);
    assign rd_valid_s = (state_r == ST_DRAIN);
    assign wr_acc_s   = wr_valid && wr_ready_s;
    assign rd_hs_s    = rd_valid_s && rd_ready;

    // Next-state and datapath update; abort is applied last so it overrides everything.
    always_comb begin
        state_n      = state_r;
        op_n         = op_r;
        res_n        = res_r;
        mask_n       = mask_r;
        timer_n      = timer_r;
        idx_n        = idx_r;
        rd_data_n    = rd_data_r;
        rd_last_n    = rd_last_r;
        core_start_n = 1'b0;
        err_to_n     = err_to_r;
        err_addr_n   = err_addr_r;
        err_inc_n    = err_inc_r;

        if (err_clr && (state_r != ST_ERR)) begin
            err_addr_n = 1'b0;
            err_inc_n  = 1'b0;
        end else begin
            err_addr_n = err_addr_r;
        end

        case (state_r)
            ST_IDLE, ST_LOAD: begin
                if (wr_acc_s) begin
                    if (wr_addr < 4'(NREGS)) begin
                        if (wr_hi) begin
                            op_n[int'(wr_addr)*WIDTH + CHUNK +: HW] = wr_data[HW-1:0];
                        end else begin
                            op_n[int'(wr_addr)*WIDTH +: CHUNK] = wr_data;
                        end
                        mask_n[int'(wr_addr)*NCHUNK + int'(wr_hi)] = 1'b1;
                    end else begin
                        err_addr_n = 1'b1;
                    end
                    state_n = ST_LOAD;
                end else begin
                    state_n = state_r;
                end
                // A write landing in the same cycle counts toward the full mask.
                if (start) begin
                    if (&mask_n) begin
                        state_n      = ST_RUN;
                        timer_n      = '0;
                        core_start_n = 1'b1;
                    end else begin
                        err_inc_n = 1'b1;
                    end
                end else begin
                    core_start_n = 1'b0;
                end
            end
            ST_RUN: begin
                if (core_done) begin
                    res_n     = res_bus;
                    state_n   = ST_DRAIN;
                    idx_n     = '0;
                    rd_data_n = chunk_sel(res_bus, '0);
                    rd_last_n = (I_LAST == '0);
                end else if (timer_r == T_LAST) begin
                    state_n  = ST_ERR;
                    err_to_n = 1'b1;
                end else if (timer_r != T_SAT) begin
                    timer_n = timer_r + TW'(1);
                end else begin
                    timer_n = timer_r;
                end
            end
            ST_DRAIN: begin
                if (rd_hs_s) begin
                    if (rd_last_r) begin
                        state_n   = ST_IDLE;
                        mask_n    = '0;
                        op_n      = '0;
                        res_n     = '0;
                        idx_n     = '0;
                        rd_data_n = '0;
                        rd_last_n = 1'b0;
                    end else begin
                        idx_n     = idx_r + IW'(1);
                        rd_data_n = chunk_sel(res_r, idx_r + IW'(1));
                        rd_last_n = ((idx_r + IW'(1)) == I_LAST);
                    end
                end else begin
                    idx_n = idx_r;
                end
            end
            ST_ERR: begin
                if (err_clr) begin
                    state_n    = ST_IDLE;
                    mask_n     = '0;
                    err_to_n   = 1'b0;
                    err_addr_n = 1'b0;
                    err_inc_n  = 1'b0;
                end else begin
                    state_n = ST_ERR;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_n      = ST_IDLE;
            mask_n       = '0;
            timer_n      = '0;
            idx_n        = '0;
            op_n         = '0;
            res_n        = '0;
            rd_data_n    = '0;
            rd_last_n    = 1'b0;
            core_start_n = 1'b0;
            err_to_n     = err_to_r;
            err_addr_n   = err_addr_r;
            err_inc_n    = err_inc_r;
        end else begin
            state_n = state_n;
        end
    end

    // State, datapath and error-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            op_r         <= '0;
            res_r        <= '0;
            mask_r       <= '0;
            timer_r      <= '0;
            idx_r        <= '0;
            rd_data_r    <= '0;
            rd_last_r    <= 1'b0;
            core_start_r <= 1'b0;
            err_to_r     <= 1'b0;
            err_addr_r   <= 1'b0;
            err_inc_r    <= 1'b0;
        end else begin
            state_r      <= state_n;
            op_r         <= op_n;
            res_r        <= res_n;
            mask_r       <= mask_n;
            timer_r      <= timer_n;
            idx_r        <= idx_n;
            rd_data_r    <= rd_data_n;
            rd_last_r    <= rd_last_n;
            core_start_r <= core_start_n;
            err_to_r     <= err_to_n;
            err_addr_r   <= err_addr_n;
            err_inc_r    <= err_inc_n;
        end
    end

    assign wr_ready       = wr_ready_s;
    assign rd_valid       = rd_valid_s;
    assign rd_data        = rd_data_r;
    assign rd_last        = rd_last_r;
    assign core_start     = core_start_r;
    assign op_bus         = op_r;
    assign busy           = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    assign state_o        = state_r;
    assign err_timeout    = err_to_r;
    assign err_addr       = err_addr_r;
    assign err_incomplete = err_inc_r;
endmodule
